mines_map_ctrl: RTL and testbench



---
 rtl/mines_pkg.sv | 47 ++++
 rtl/mines_map_ctrl_if.sv | 23 ++
 rtl/mines_row_popcount.sv | 16 +
 rtl/mines_map_ctrl.sv | 130 +++++++++++++
 tb/tb_mines_map_ctrl.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/mines_pkg.sv
// Shared constants, types and the constant level table for the mine map.
// Levels are listed as (row, column) mine positions so the table stays readable.
// Rows are ascending packed vectors: bit [x] of a row is tile column x.
package mines_pkg;

  localparam int NUM_LEVELS = 7;
  localparam int ROWS       = 15;
  localparam int COLS       = 20;
  localparam int TILE_SHIFT = 5;

  typedef logic [0:COLS-1]              tile_row_t;
  typedef tile_row_t [0:ROWS-1]         level_map_t;
  typedef level_map_t [0:NUM_LEVELS-1]  level_table_t;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} ctrl_state_t;

  // Builds the level table; indices are m[level][row y][column x].
  function automatic level_table_t build_mine_map();
    level_table_t m;
    m = '0;
    // level 0: 3 mines
    m[0][9][16] = 1'b1;  m[0][2][3] = 1'b1;  m[0][12][10] = 1'b1;
    // level 1: 5 mines
    m[1][0][0] = 1'b1;   m[1][5][5] = 1'b1;  m[1][7][12] = 1'b1;
    m[1][10][19] = 1'b1; m[1][14][8] = 1'b1;
    // level 2: 6 mines
    m[2][1][1] = 1'b1;   m[2][3][7] = 1'b1;  m[2][6][14] = 1'b1;
    m[2][8][2] = 1'b1;   m[2][11][17] = 1'b1; m[2][13][9] = 1'b1;
    // level 3: 8 mines
    m[3][0][19] = 1'b1;  m[3][2][10] = 1'b1; m[3][4][4] = 1'b1;
    m[3][6][6] = 1'b1;   m[3][9][1] = 1'b1;  m[3][10][15] = 1'b1;
    m[3][12][12] = 1'b1; m[3][14][0] = 1'b1;
    // level 4: 10 mines, none shared with level 0
    m[4][1][4] = 1'b1;   m[4][2][15] = 1'b1; m[4][3][9] = 1'b1;
    m[4][5][1] = 1'b1;   m[4][6][18] = 1'b1; m[4][7][7] = 1'b1;
    m[4][8][11] = 1'b1;  m[4][11][3] = 1'b1; m[4][13][16] = 1'b1;
    m[4][14][13] = 1'b1;
    // level 5: 12 mines on a diagonal stride
    for (int r = 0; r < 12; r++) m[5][r][(r * 3) % COLS] = 1'b1;
    // level 6: 15 mines, one per row
    for (int r = 0; r < ROWS; r++) m[6][r][(r * 7 + 1) % COLS] = 1'b1;
    return m;
  endfunction

  localparam level_table_t MINE_MAP = build_mine_map();

endpackage

// File: rtl/mines_map_ctrl_if.sv
// Bundles the game-side control, VGA lookup and status signals of the mine map controller.
// master = game/VGA side driving requests, slave = the controller itself.
interface mines_map_ctrl_if;
  logic [3:0]  level;
  logic        loadReq;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        collision;
  logic        drawingRequest;
  logic [8:0]  minesLeft;
  logic        levelCleared;
  logic        busy;

  modport master (
    output level, loadReq, pixelX, pixelY, collision,
    input  drawingRequest, minesLeft, levelCleared, busy
  );

  modport slave (
    input  level, loadReq, pixelX, pixelY, collision,
    output drawingRequest, minesLeft, levelCleared, busy
  );
endinterface

// File: rtl/mines_row_popcount.sv
// Counts the mines in one tile row.
// Purely combinational, zero latency; no flow control.
import mines_pkg::*;

module mines_row_popcount (
  input  tile_row_t   row,
  output logic [4:0]  count
);

  // Sum of set bits across the row (max 20 fits in 5 bits).
  always_comb begin
    count = '0;
    for (int i = 0; i < COLS; i++) count = count + {4'b0, row[i]};
  end

endmodule

// File: rtl/mines_map_ctrl.sv
// Live mine map: row-per-cycle reload from the level table, registered pixel lookup, collision clears.
// Lookup latency 1 cycle; reload takes 15 cycles with busy high; clear visible the cycle after collision.
// No backpressure: loadReq always restarts a load and wins over a same-cycle collision clear.
import mines_pkg::*;

module mines_map_ctrl (
  input  logic             clk,
  input  logic             resetN,
  mines_map_ctrl_if.slave  bus
);

  ctrl_state_t  state, state_nxt;
  logic [3:0]   row_idx;
  logic [3:0]   lvl_q;
  level_map_t   live;
  logic         busy_c;

  logic [10:0]  tx_full, ty_full;
  logic         in_map;
  logic [4:0]   tx_i, tx_q;
  logic [3:0]   ty_i, ty_q;
  logic         vld_q;

  tile_row_t    src_row;
  logic [4:0]   row_cnt;
  logic         clear_en;

  logic [8:0]   mines_q;
  logic         draw_q;
  logic         cleared_q;

  mines_row_popcount u_popcount (
    .row   (src_row),
    .count (row_cnt)
  );

  // Tile addressing for the current pixel; out-of-map pixels use a safe index and are masked.
  always_comb begin
    tx_full = bus.pixelX >> TILE_SHIFT;
    ty_full = bus.pixelY >> TILE_SHIFT;
    in_map  = (tx_full < 11'(COLS)) && (ty_full < 11'(ROWS));
    tx_i    = in_map ? tx_full[4:0] : '0;
    ty_i    = in_map ? ty_full[3:0] : '0;
  end

  // Source row for the load and the collision clear qualifier.
  always_comb begin
    src_row  = '0;
    if (lvl_q < 4'(NUM_LEVELS)) src_row = MINE_MAP[lvl_q[2:0]][row_idx];
    clear_en = (state == RUN) && bus.collision && vld_q && live[ty_q][tx_q] && !bus.loadReq;
  end

  // State register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; a load request restarts loading from any state.
  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    case (state)
      IDLE: if (bus.loadReq) state_nxt = LOAD;
      LOAD: begin
        busy_c = 1'b1;
        if (bus.loadReq)                    state_nxt = LOAD;
        else if (row_idx == 4'(ROWS - 1))   state_nxt = RUN;
      end
      RUN:  if (bus.loadReq) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  // Map, count and lookup pipeline; the load port and the clear port are never active together.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      live      <= '0;
      row_idx   <= '0;
      lvl_q     <= '0;
      mines_q   <= '0;
      draw_q    <= 1'b0;
      cleared_q <= 1'b0;
      vld_q     <= 1'b0;
      tx_q      <= '0;
      ty_q      <= '0;
    end else begin
      cleared_q <= 1'b0;
      if (bus.loadReq) begin
        lvl_q   <= bus.level;
        row_idx <= '0;
        mines_q <= '0;
        draw_q  <= 1'b0;
        vld_q   <= 1'b0;
      end else begin
        case (state)
          LOAD: begin
            live[row_idx] <= src_row;
            mines_q       <= mines_q + {4'b0, row_cnt};
            row_idx       <= row_idx + 4'd1;
            draw_q        <= 1'b0;
            vld_q         <= 1'b0;
          end
          RUN: begin
            // Lookup reads the map before this cycle's clear takes effect.
            draw_q <= in_map && live[ty_i][tx_i];
            vld_q  <= in_map;
            tx_q   <= tx_i;
            ty_q   <= ty_i;
            if (clear_en) begin
              live[ty_q][tx_q] <= 1'b0;
              mines_q          <= mines_q - 9'd1;
              cleared_q        <= (mines_q == 9'd1);
            end
          end
          default: begin
            draw_q <= 1'b0;
            vld_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.drawingRequest = draw_q;
  assign bus.minesLeft      = mines_q;
  assign bus.levelCleared   = cleared_q;
  assign bus.busy           = busy_c;

endmodule

// File: tb/tb_mines_map_ctrl.sv
// Randomized and directed bench for mines_map_ctrl against a tile-level reference model.
// The model loads a whole level at once and only tracks visible behaviour.
import mines_pkg::*;

module tb_mines_map_ctrl;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  mines_map_ctrl_if bus ();

  mines_map_ctrl dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;

  // reference model state: 0 idle, 1 loading, 2 running
  int m_mode;
  int m_left;
  int m_count;
  bit m_map [ROWS][COLS];
  bit m_pv;
  int m_ptx, m_pty;
  bit e_dr, e_lc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_left = 0; m_count = 0; m_pv = 0; m_ptx = 0; m_pty = 0;
    e_dr = 0; e_lc = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) m_map[r][c] = 0;
  endtask

  task automatic model_step(input bit lr, input int lvl, input int px, input int py, input bit col);
    int tx, ty;
    bit inm;
    e_lc = 0;
    if (lr) begin
      m_mode = 1; m_left = 15; m_count = 0; e_dr = 0; m_pv = 0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          m_map[r][c] = 0;
          if (lvl < NUM_LEVELS) m_map[r][c] = MINE_MAP[lvl][r][c];
          m_count += int'(m_map[r][c]);
        end
    end else if (m_mode == 1) begin
      m_left--;
      if (m_left == 0) m_mode = 2;
      e_dr = 0; m_pv = 0;
    end else if (m_mode == 2) begin
      tx = px / 32; ty = py / 32;
      inm = (tx < COLS) && (ty < ROWS);
      e_dr = inm && m_map[ty][tx];
      if (col && m_pv && m_map[m_pty][m_ptx]) begin
        m_map[m_pty][m_ptx] = 0;
        m_count--;
        e_lc = (m_count == 0);
      end
      m_pv = inm; m_ptx = tx; m_pty = ty;
    end else begin
      e_dr = 0;
    end
  endtask

  // One clock with the given inputs, then compare every output against the model.
  task automatic cyc(input bit lr, input int lvl, input int px, input int py, input bit col);
    bus.loadReq   = lr;
    bus.level     = 4'(lvl);
    bus.pixelX    = 11'(px);
    bus.pixelY    = 11'(py);
    bus.collision = col;
    @(posedge clk);
    model_step(lr, lvl, px, py, col);
    #1;
    check("busy", 32'(bus.busy), 32'(m_mode == 1));
    check("drawingRequest", 32'(bus.drawingRequest), 32'(e_dr));
    check("levelCleared", 32'(bus.levelCleared), 32'(e_lc));
    if (m_mode != 1) check("minesLeft", 32'(bus.minesLeft), 32'(m_count));
  endtask

  int nb, nd, px, py, lvl;
  bit lr, col;

  initial begin
    bus.loadReq = 0; bus.level = 0; bus.pixelX = 0; bus.pixelY = 0; bus.collision = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_draw", 32'(bus.drawingRequest), 0);
    check("rst_mines", 32'(bus.minesLeft), 0);
    check("rst_cleared", 32'(bus.levelCleared), 0);
    @(negedge clk);
    resetN = 1'b1;

    // idle: collisions and mine pixels have no effect
    repeat (3) cyc(0, 0, 512, 290, 1);

    // level 0 load: busy for exactly 15 cycles, collisions ignored meanwhile
    cyc(1, 0, 512, 290, 1);
    nb = int'(bus.busy);
    repeat (15) begin
      cyc(0, 0, 512, 290, 1);
      nb += int'(bus.busy);
    end
    check("load_busy_cycles", 32'(nb), 15);
    check("mines_level0", 32'(bus.minesLeft), 3);

    // lookups
    cyc(0, 0, 512, 290, 0);
    check("draw_tile_16_9", 32'(bus.drawingRequest), 1);
    cyc(0, 0, 500, 290, 0);
    check("draw_tile_15_9", 32'(bus.drawingRequest), 0);

    // held collision decrements once
    cyc(0, 0, 512, 290, 0);
    repeat (32) cyc(0, 0, 512, 290, 1);
    check("mines_after_hold", 32'(bus.minesLeft), 2);
    check("draw_after_clear", 32'(bus.drawingRequest), 0);

    // clear the remaining two mines
    cyc(0, 0, 100, 70, 0);
    cyc(0, 0, 100, 70, 1);
    check("mines_one_left", 32'(bus.minesLeft), 1);
    check("no_early_pulse", 32'(bus.levelCleared), 0);
    cyc(0, 0, 330, 400, 0);
    cyc(0, 0, 330, 400, 1);
    check("cleared_pulse", 32'(bus.levelCleared), 1);
    check("mines_zero", 32'(bus.minesLeft), 0);
    cyc(0, 0, 330, 400, 1);
    check("cleared_single", 32'(bus.levelCleared), 0);

    // restart mid-load at row 7 with level 4
    cyc(1, 0, 0, 0, 0);
    repeat (7) cyc(0, 0, 0, 0, 0);
    cyc(1, 4, 0, 0, 0);
    repeat (15) cyc(0, 0, 0, 0, 0);
    check("restart_busy_done", 32'(bus.busy), 0);
    check("mines_level4", 32'(bus.minesLeft), 10);
    nd = 0;
    for (int ty = 0; ty < ROWS; ty++)
      for (int tx = 0; tx < COLS; tx++) begin
        cyc(0, 0, tx * 32 + 5, ty * 32 + 7, 0);
        nd += int'(bus.drawingRequest);
      end
    check("scan_draws_level4", 32'(nd), 10);

    // out-of-map pixel: no draw, collision ignored
    cyc(0, 0, 700, 100, 0);
    check("draw_out_of_map", 32'(bus.drawingRequest), 0);
    cyc(0, 0, 700, 100, 1);
    check("mines_out_of_map", 32'(bus.minesLeft), 10);

    // same-cycle collision and load request: load wins
    cyc(0, 0, 4 * 32 + 3, 1 * 32 + 3, 0);
    cyc(1, 9, 4 * 32 + 3, 1 * 32 + 3, 1);
    repeat (15) cyc(0, 0, 0, 0, 0);
    check("mines_level9", 32'(bus.minesLeft), 0);
    for (int i = 0; i < 20; i++) cyc(0, 0, i * 37, i * 29, 1);

    // randomized traffic
    cyc(1, 6, 0, 0, 0);
    px = 0; py = 0;
    for (int i = 0; i < 3000; i++) begin
      lr  = ($urandom_range(0, 199) == 0);
      lvl = $urandom_range(0, 8);
      if ($urandom_range(0, 1) == 0) begin
        px = $urandom_range(0, 799);
        py = $urandom_range(0, 599);
      end
      col = ($urandom_range(0, 2) == 0);
      cyc(lr, lvl, px, py, col);
    end

    // asynchronous reset while running
    cyc(1, 4, 0, 0, 0);
    repeat (15) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 4 * 32 + 3, 1 * 32 + 3, 0);
    check("pre_reset_draw", 32'(bus.drawingRequest), 1);
    #2;
    resetN = 1'b0;
    #1;
    check("arst_busy", 32'(bus.busy), 0);
    check("arst_draw", 32'(bus.drawingRequest), 0);
    check("arst_mines", 32'(bus.minesLeft), 0);
    check("arst_cleared", 32'(bus.levelCleared), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
